// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// with a memory ready handshake, wait timeout, illegal-op trap and retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction at PC; on mem_ready load IR and PC+4
// DECODE | classify instruction; jumps complete here
// EXEC   | ALU operation; branches complete here
// MEM    | data load/store at ALU result address
// WB     | GPR write-back
// TRAP   | illegal encoding or memory timeout; left only through reset
module mc_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32,
    parameter bit          TRAP_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             RegWrite,
    output logic             EXTOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       NPCOp,
    output logic [1:0]       GPRSel,
    output logic [1:0]       WDSel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_ILL, C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_JALR
    } cls_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       ext_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] npc_op;
        logic [1:0] gpr_sel;
        logic [1:0] wd_sel;
    } ctl_t;

    localparam logic [3:0] ALU_ADD = 4'd1,  ALU_SUB  = 4'd2,  ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4,  ALU_SLT  = 4'd5,  ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7,  ALU_SRL  = 4'd8,  ALU_NOR = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10, ALU_XOR  = 4'd11, ALU_SRA = 4'd12;
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] instret_q;
    cls_e             cls;
    logic [3:0]       alu_op;
    logic [1:0]       src_b;
    logic             ext_op;
    logic             pending, timeout, retire;
    ctl_t             ctl;

    always_comb begin
        cls    = C_ILL;
        alu_op = ALU_ADD;
        src_b  = 2'b00;
        ext_op = 1'b0;
        if (Op == 6'b000000) begin
            case (Funct)
                6'b100000, 6'b100001: begin cls = C_RALU; alu_op = ALU_ADD;  end
                6'b100010, 6'b100011: begin cls = C_RALU; alu_op = ALU_SUB;  end
                6'b100100:            begin cls = C_RALU; alu_op = ALU_AND;  end
                6'b100101:            begin cls = C_RALU; alu_op = ALU_OR;   end
                6'b100110:            begin cls = C_RALU; alu_op = ALU_XOR;  end
                6'b100111:            begin cls = C_RALU; alu_op = ALU_NOR;  end
                6'b101010:            begin cls = C_RALU; alu_op = ALU_SLT;  end
                6'b101011:            begin cls = C_RALU; alu_op = ALU_SLTU; end
                6'b000000:            begin cls = C_RALU; alu_op = ALU_SLL;  end
                6'b000010:            begin cls = C_RALU; alu_op = ALU_SRL;  end
                6'b000011:            begin cls = C_RALU; alu_op = ALU_SRA;  end
                6'b001000:            cls = C_JR;
                6'b001001:            cls = C_JALR;
                default:              cls = C_ILL;
            endcase
        end else begin
            src_b = 2'b10;
            case (Op)
                6'b001000: begin cls = C_IALU; ext_op = 1'b1; end
                6'b001100: begin cls = C_IALU; alu_op = ALU_AND; end
                6'b001101: begin cls = C_IALU; alu_op = ALU_OR;  end
                6'b001010: begin cls = C_IALU; alu_op = ALU_SLT; ext_op = 1'b1; end
                6'b001111: begin cls = C_IALU; alu_op = ALU_LUI; end
                6'b100011: begin cls = C_LW;   ext_op = 1'b1; end
                6'b101011: begin cls = C_SW;   ext_op = 1'b1; end
                6'b000100: begin cls = C_BEQ;  alu_op = ALU_SUB; src_b = 2'b00; end
                6'b000101: begin cls = C_BNE;  alu_op = ALU_SUB; src_b = 2'b00; end
                6'b000010: cls = C_J;
                6'b000011: cls = C_JAL;
                default:   cls = C_ILL;
            endcase
        end
    end

    assign pending = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timeout = pending && !mem_ready && (wait_q >= WAIT_LIM - 8'd1);

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end else if (timeout && TRAP_EN) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_J, C_JAL: begin
                        ctl.pc_write = 1'b1;
                        ctl.npc_op   = 2'b10;
                        if (cls == C_JAL) begin
                            ctl.reg_write = 1'b1;
                            ctl.gpr_sel   = 2'b10;
                            ctl.wd_sel    = 2'b10;
                        end
                        state_d = S_FETCH;
                    end
                    C_JR, C_JALR: begin
                        ctl.pc_write = 1'b1;
                        ctl.npc_op   = 2'b11;
                        if (cls == C_JALR) begin
                            ctl.reg_write = 1'b1;
                            ctl.wd_sel    = 2'b10;
                        end
                        state_d = S_FETCH;
                    end
                    C_ILL:   state_d = TRAP_EN ? S_TRAP : S_FETCH;
                    default: state_d = S_EXEC;
                endcase
            end
            // ALU controls stay asserted through MEM/WB so the unregistered ALU result holds
            S_EXEC, S_MEM, S_WB: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = src_b;
                ctl.alu_op    = alu_op;
                ctl.ext_op    = ext_op;
                if (state_q == S_EXEC) begin
                    if (cls == C_BEQ || cls == C_BNE) begin
                        ctl.npc_op   = 2'b01;
                        ctl.pc_write = (cls == C_BEQ) ? Zero : !Zero;
                        state_d      = S_FETCH;
                    end else if (cls == C_LW || cls == C_SW) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (state_q == S_MEM) begin
                    ctl.iord      = 1'b1;
                    ctl.mem_read  = (cls == C_LW);
                    ctl.mem_write = (cls == C_SW);
                    if (mem_ready) begin
                        state_d = (cls == C_LW) ? S_WB : S_FETCH;
                    end else if (timeout && TRAP_EN) begin
                        state_d = S_TRAP;
                    end
                end else begin
                    ctl.reg_write = 1'b1;
                    ctl.wd_sel    = (cls == C_LW) ? 2'b01 : 2'b00;
                    ctl.gpr_sel   = (cls == C_RALU) ? 2'b00 : 2'b01;
                    state_d       = S_FETCH;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q || mem_ready) begin
            wait_d = 8'd0;
        end else if (pending && wait_q != WAIT_LIM) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, EXTOp, ALUSrcA,
            ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel} = rstn ? ctl : '0;
    assign state   = state_q;
    assign trap    = (state_q == S_TRAP);
    assign instret = instret_q;

endmodule
